// File: rtl/trace_line_parser.sv
// Parses ASCII "op address" trace lines into records buffered in a FWFT FIFO.
// Optional err_line output enabled by TRACE_PARSER_ERRLINE_EN.
module trace_line_parser #(
  parameter int ADDR_W  = 32,
  parameter int FIFO_AW = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_en,
  input  logic [7:0]        in_byte,
  output logic              o_valid,
  input  logic              o_ready,
  output logic              o_write,
  output logic [ADDR_W-1:0] o_addr,
  output logic [FIFO_AW:0]  fifo_level,
  output logic [15:0]       rec_count,
  output logic              err_fmt,
  output logic              err_ovf
`ifdef TRACE_PARSER_ERRLINE_EN
  ,
  output logic [15:0]       err_line
`endif
);

  localparam int ND    = ADDR_W / 4;
  localparam int DW    = $clog2(ND + 1);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [2:0] {
    S_OP, S_SEP, S_HEX, S_TAIL, S_SKIP
  } state_t;

  state_t state, state_nx;

  logic              op, op_nx;
  logic [ADDR_W-1:0] acc, acc_nx;
  logic [DW-1:0]     dig, dig_nx;
  logic              pfx, pfx_nx;
  logic              sep, sep_nx;
  logic              push, bad;

  logic       is_ws, is_cr, is_lf, is_r, is_w, is_x;
  logic       is_hex;
  logic [3:0] nib;

  assign is_ws = (in_byte == 8'h20) || (in_byte == 8'h09);
  assign is_cr = (in_byte == 8'h0D);
  assign is_lf = (in_byte == 8'h0A);
  assign is_r  = (in_byte == 8'h52) || (in_byte == 8'h72);
  assign is_w  = (in_byte == 8'h57) || (in_byte == 8'h77);
  assign is_x  = (in_byte == 8'h58) || (in_byte == 8'h78);

  always_comb begin
    is_hex = 1'b0;
    nib    = 4'h0;
    unique case (1'b1)
      (in_byte >= 8'h30 && in_byte <= 8'h39): begin
        is_hex = 1'b1;
        nib    = in_byte[3:0];
      end
      (in_byte >= 8'h41 && in_byte <= 8'h46),
      (in_byte >= 8'h61 && in_byte <= 8'h66): begin
        is_hex = 1'b1;
        nib    = in_byte[3:0] + 4'd9;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_OP;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (in_en) begin
      unique case (state)
        S_OP: begin
          if (is_r || is_w)
            state_nx = S_SEP;
          else if (!(is_ws || is_cr || is_lf))
            state_nx = S_SKIP;
        end
        S_SEP: begin
          if (is_ws)               state_nx = S_SEP;
          else if (is_hex && sep)  state_nx = S_HEX;
          else if (is_lf)          state_nx = S_OP;
          else                     state_nx = S_SKIP;
        end
        S_HEX: begin
          if (is_hex)
            state_nx = (dig == DW'(ND)) ? S_SKIP : S_HEX;
          else if (is_x)
            state_nx = (dig == DW'(1) && acc == '0 && !pfx)
                     ? S_HEX : S_SKIP;
          else if (is_ws || is_cr)
            state_nx = (dig != '0) ? S_TAIL : S_SKIP;
          else if (is_lf)
            state_nx = S_OP;
          else
            state_nx = S_SKIP;
        end
        S_TAIL: begin
          if (is_lf)                      state_nx = S_OP;
          else if (!(is_ws || is_cr))     state_nx = S_SKIP;
        end
        S_SKIP: begin
          if (is_lf) state_nx = S_OP;
        end
        default: state_nx = S_OP;
      endcase
    end
  end

  always_comb begin
    op_nx  = op;
    acc_nx = acc;
    dig_nx = dig;
    pfx_nx = pfx;
    sep_nx = sep;
    push   = 1'b0;
    bad    = 1'b0;
    if (in_en) begin
      unique case (state)
        S_OP: begin
          if (is_r || is_w) begin
            op_nx  = is_w;
            acc_nx = '0;
            dig_nx = '0;
            pfx_nx = 1'b0;
            sep_nx = 1'b0;
          end else if (!(is_ws || is_cr || is_lf)) begin
            bad = 1'b1;
          end
        end
        S_SEP: begin
          if (is_ws) begin
            sep_nx = 1'b1;
          end else if (is_hex && sep) begin
            acc_nx = ADDR_W'(nib);
            dig_nx = DW'(1);
          end else begin
            bad = 1'b1;
          end
        end
        S_HEX: begin
          if (is_hex) begin
            if (dig == DW'(ND)) begin
              bad = 1'b1;
            end else begin
              acc_nx = {acc[ADDR_W-5:0], nib};
              dig_nx = dig + DW'(1);
            end
          end else if (is_x) begin
            if (dig == DW'(1) && acc == '0 && !pfx) begin
              pfx_nx = 1'b1;
              dig_nx = '0;
            end else begin
              bad = 1'b1;
            end
          end else if (is_ws || is_cr) begin
            bad = (dig == '0);
          end else if (is_lf) begin
            push = (dig != '0);
            bad  = (dig == '0);
          end else begin
            bad = 1'b1;
          end
        end
        S_TAIL: begin
          if (is_lf)                  push = 1'b1;
          else if (!(is_ws || is_cr)) bad  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op  <= 1'b0;
      acc <= '0;
      dig <= '0;
      pfx <= 1'b0;
      sep <= 1'b0;
    end else begin
      op  <= op_nx;
      acc <= acc_nx;
      dig <= dig_nx;
      pfx <= pfx_nx;
      sep <= sep_nx;
    end
  end

  logic [ADDR_W:0]    mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic               pop, push_ok;
  logic [ADDR_W:0]    head;

  assign o_valid = (fifo_level != '0);
  assign pop     = o_valid && o_ready;
  // A full FIFO still takes a push when the head leaves the same cycle.
  assign push_ok = push && ((fifo_level != FULL) || pop);
  assign head    = mem[rd_ptr];
  assign o_write = o_valid ? head[ADDR_W] : 1'b0;
  assign o_addr  = o_valid ? head[ADDR_W-1:0] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {op, acc};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      rec_count  <= '0;
      err_fmt    <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr    <= wr_ptr + 1'b1;
        rec_count <= rec_count + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      fifo_level <= fifo_level + 1'b1;
      else if (!push_ok && pop) fifo_level <= fifo_level - 1'b1;
      if (bad)               err_fmt <= 1'b1;
      if (push && !push_ok)  err_ovf <= 1'b1;
    end
  end

`ifdef TRACE_PARSER_ERRLINE_EN
  logic [15:0] line_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      line_cnt <= '0;
      err_line <= '0;
    end else begin
      if (in_en && is_lf && line_cnt != 16'hFFFF)
        line_cnt <= line_cnt + 16'd1;
      if (bad && err_line == '0)
        err_line <= (line_cnt == 16'hFFFF) ? 16'hFFFF
                                           : line_cnt + 16'd1;
    end
  end
`endif

endmodule
